// File: rtl/alu_pkg.sv
// alu_pkg: operation codes, execute-stage state encoding and width defaults
// shared by the ALU control decoder and the execute unit. Rev 1.0
`default_nettype none

package alu_pkg;

   localparam int XLEN_DEF = 32;

   localparam logic [3:0] ALU_AND = 4'b0000;
   localparam logic [3:0] ALU_OR  = 4'b0001;
   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_SLL = 4'b0011;
   localparam logic [3:0] ALU_SRL = 4'b0100;
   localparam logic [3:0] ALU_SRA = 4'b0101;
   localparam logic [3:0] ALU_SUB = 4'b0110;
   localparam logic [3:0] ALU_SLT = 4'b0111;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   function automatic logic is_shift(input logic [3:0] ctrl);
      return (ctrl == ALU_SLL) || (ctrl == ALU_SRL) || (ctrl == ALU_SRA);
   endfunction

endpackage

`default_nettype wire

// File: rtl/alu_comb_core.sv
// alu_comb_core: single-cycle AND/OR/ADD/SUB/SLT plus illegal-code detection.
// Rev 1.0
`default_nettype none

module alu_comb_core
   import alu_pkg::*;
#(
   parameter int XLEN = XLEN_DEF
) (
   input  logic [3:0]      i_ctrl,
   input  logic [XLEN-1:0] i_a,
   input  logic [XLEN-1:0] i_b,
   output logic [XLEN-1:0] o_result,
   output logic            o_illegal
);

   always_comb begin
      o_result  = '0;
      o_illegal = 1'b0;
      case (i_ctrl)
         ALU_AND: o_result = i_a & i_b;
         ALU_OR:  o_result = i_a | i_b;
         ALU_ADD: o_result = i_a + i_b;
         ALU_SUB: o_result = i_a - i_b;
         ALU_SLT: o_result = {{(XLEN-1){1'b0}}, ($signed(i_a) < $signed(i_b))};
         // Shifts are legal but produced by the iterative path in the parent.
         ALU_SLL, ALU_SRL, ALU_SRA: o_result = '0;
         default: o_illegal = 1'b1;
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: multi-cycle execute stage; 1-cycle logic/arith ops and
// bit-serial shifts behind valid/ready handshakes. Rev 1.0
`default_nettype none

module alu_exec_unit
   import alu_pkg::*;
#(
   parameter int XLEN    = XLEN_DEF,
   parameter int SHAMT_W = 5
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [3:0]      alu_ctrl,
   input  logic [XLEN-1:0] op_a,
   input  logic [XLEN-1:0] op_b,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] result,
   output logic            zero,
   output logic            illegal
);

   state_t              r_state;
   state_t              w_next;
   logic [SHAMT_W-1:0]  r_count;
   logic [XLEN-1:0]     r_work;
   logic [XLEN-1:0]     r_result;
   logic [3:0]          r_op;
   logic                r_zero;
   logic                r_illegal;

   logic [XLEN-1:0]     w_core_result;
   logic                w_core_illegal;
   logic [XLEN-1:0]     w_imm_result;
   logic [XLEN-1:0]     w_shifted;
   logic [SHAMT_W-1:0]  w_shamt;
   logic                w_accept;
   logic                w_start_shift;
   logic                w_last_shift;

   alu_comb_core #(.XLEN(XLEN)) u_core (
      .i_ctrl    (alu_ctrl),
      .i_a       (op_a),
      .i_b       (op_b),
      .o_result  (w_core_result),
      .o_illegal (w_core_illegal)
   );

   assign w_shamt       = op_b[SHAMT_W-1:0];
   assign w_accept      = in_valid && (r_state == IDLE);
   assign w_start_shift = is_shift(alu_ctrl) && (w_shamt != '0);
   // A zero-distance shift is just a pass-through of operand A.
   assign w_imm_result  = is_shift(alu_ctrl) ? op_a : w_core_result;
   assign w_last_shift  = (r_count == SHAMT_W'(1));

   always_comb begin
      w_shifted = {r_work[XLEN-1], r_work[XLEN-1:1]};
      case (r_op)
         ALU_SLL: w_shifted = {r_work[XLEN-2:0], 1'b0};
         ALU_SRL: w_shifted = {1'b0, r_work[XLEN-1:1]};
         default: w_shifted = {r_work[XLEN-1], r_work[XLEN-1:1]};
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (w_accept) w_next = w_start_shift ? SHIFT : DONE;
         SHIFT:   if (w_last_shift) w_next = DONE;
         DONE:    if (out_ready) w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count   <= '0;
         r_work    <= '0;
         r_result  <= '0;
         r_op      <= '0;
         r_zero    <= 1'b0;
         r_illegal <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_op <= alu_ctrl;
                  if (w_start_shift) begin
                     r_work  <= op_a;
                     r_count <= w_shamt;
                  end else begin
                     r_result  <= w_imm_result;
                     r_zero    <= (w_imm_result == '0);
                     r_illegal <= w_core_illegal;
                  end
               end
            end
            SHIFT: begin
               r_work  <= w_shifted;
               r_count <= r_count - SHAMT_W'(1);
               if (w_last_shift) begin
                  r_result  <= w_shifted;
                  r_zero    <= (w_shifted == '0);
                  r_illegal <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   assign in_ready  = (r_state == IDLE);
   assign out_valid = (r_state == DONE);
   assign result    = r_result;
   assign zero      = r_zero;
   assign illegal   = r_illegal;

endmodule

`default_nettype wire

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit: directed and randomized operations checked every cycle
// against a transaction-level model of the execute unit. Rev 1.0
`default_nettype none

module tb_alu_exec_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  alu_ctrl;
   logic [31:0] op_a;
   logic [31:0] op_b;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] result;
   logic        zero;
   logic        illegal;

   int n_checks = 0;
   int n_fail   = 0;

   alu_exec_unit #(.XLEN(32), .SHAMT_W(5)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .alu_ctrl  (alu_ctrl),
      .op_a      (op_a),
      .op_b      (op_b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .zero      (zero),
      .illegal   (illegal)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference semantics of one operation: result, legality, cycles to valid.
   function automatic logic [31:0] ref_result(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
      case (c)
         4'b0000: return a & b;
         4'b0001: return a | b;
         4'b0010: return a + b;
         4'b0110: return a - b;
         4'b0111: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         4'b0011: return a << b[4:0];
         4'b0100: return a >> b[4:0];
         4'b0101: return $unsigned($signed(a) >>> b[4:0]);
         default: return 32'd0;
      endcase
   endfunction

   function automatic int ref_latency(input logic [3:0] c, input logic [31:0] b);
      if ((c == 4'b0011 || c == 4'b0100 || c == 4'b0101) && b[4:0] != 5'd0)
         return int'(b[4:0]) + 1;
      return 1;
   endfunction

   // Transaction model: busy from accept until the handshake completes.
   logic        m_busy = 1'b0;
   int          m_cnt  = 0;
   int          m_lat  = 1;
   logic [31:0] m_exp  = '0;
   logic        m_ill  = 1'b0;
   logic        m_valid;

   assign m_valid = m_busy && (m_cnt >= m_lat);

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_busy = 1'b0;
         m_cnt  = 0;
      end else if (m_busy) begin
         if (m_cnt >= m_lat) begin
            if (out_ready) m_busy = 1'b0;
         end else begin
            m_cnt++;
         end
      end else if (in_valid) begin
         m_busy = 1'b1;
         m_cnt  = 1;
         m_exp  = ref_result(alu_ctrl, op_a, op_b);
         m_ill  = (alu_ctrl > 4'd7);
         m_lat  = ref_latency(alu_ctrl, op_b);
      end
   end

   always @(negedge clk) begin
      if (!rst_n) begin
         chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
         chk("reset_result", result, 32'd0);
         chk("reset_flags", {30'd0, zero, illegal}, 32'd0);
      end else begin
         chk("in_ready", {31'd0, in_ready}, {31'd0, !m_busy});
         chk("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
         if (m_valid) begin
            chk("result", result, m_exp);
            chk("zero", {31'd0, zero}, {31'd0, (m_exp == 32'd0)});
            chk("illegal", {31'd0, illegal}, {31'd0, m_ill});
         end
      end
   end

   // One full transaction; optional literal expectations pin the model.
   task automatic run_op(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                         input int hold, input bit lit, input logic [31:0] exp_r,
                         input logic exp_z, input logic exp_ill, input int exp_lat);
      int t;
      int lat;
      t = 0;
      while (!in_ready && t < 100) begin
         @(negedge clk);
         t++;
      end
      if (t >= 100) begin
         n_checks++;
         n_fail++;
         $display("FAIL in_ready_timeout: got 0 expected 1");
      end
      alu_ctrl  = c;
      op_a      = a;
      op_b      = b;
      in_valid  = 1'b1;
      out_ready = 1'b0;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      alu_ctrl = 4'($urandom);
      op_a     = $urandom;
      op_b     = $urandom;
      lat = 1;
      while (!out_valid && lat < 40) begin
         out_ready = 1'($urandom);
         @(negedge clk);
         lat++;
      end
      out_ready = 1'b0;
      if (lit) begin
         chk("lit_latency", lat, exp_lat);
         chk("lit_result", result, exp_r);
         chk("lit_zero", {31'd0, zero}, {31'd0, exp_z});
         chk("lit_illegal", {31'd0, illegal}, {31'd0, exp_ill});
      end
      repeat (hold) @(negedge clk);
      if (lit) chk("lit_hold_result", result, exp_r);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      if (lit) chk("lit_in_ready_after", {31'd0, in_ready}, 32'd1);
   endtask

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      alu_ctrl  = '0;
      op_a      = '0;
      op_b      = '0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Reset in the middle of a long shift.
      alu_ctrl = 4'b0011;
      op_a     = 32'h1;
      op_b     = 32'd20;
      in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (4) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("post_reset_in_ready", {31'd0, in_ready}, 32'd1);
      chk("post_reset_out_valid", {31'd0, out_valid}, 32'd0);
      run_op(4'b0010, 32'd3, 32'd4, 0, 1'b1, 32'd7, 1'b0, 1'b0, 1);

      run_op(4'b0010, 32'hFFFF_FFFF, 32'd1, 0, 1'b1, 32'd0, 1'b1, 1'b0, 1);
      run_op(4'b0110, 32'd5, 32'd7, 0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1);
      run_op(4'b0101, 32'h8000_0000, 32'd31, 0, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 32);
      run_op(4'b0100, 32'h8000_0000, 32'd31, 0, 1'b1, 32'h0000_0001, 1'b0, 1'b0, 32);
      run_op(4'b0011, 32'h1234, 32'h20, 0, 1'b1, 32'h1234, 1'b0, 1'b0, 1);
      run_op(4'b0001, 32'hF0, 32'h0F, 4, 1'b1, 32'hFF, 1'b0, 1'b0, 1);
      run_op(4'b1111, 32'h55, 32'hAA, 1, 1'b1, 32'd0, 1'b1, 1'b1, 1);
      run_op(4'b0111, 32'hFFFF_FFFF, 32'd1, 0, 1'b1, 32'd1, 1'b0, 1'b0, 1);
      run_op(4'b0011, 32'h0000_0003, 32'd4, 2, 1'b1, 32'h30, 1'b0, 1'b0, 5);

      for (int i = 0; i < 60; i++) begin
         logic [3:0] c;
         c = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 7));
         run_op(c, $urandom, $urandom, $urandom_range(0, 3), 1'b0, 32'd0, 1'b0, 1'b0, 0);
      end

      repeat (2) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Multi-cycle execute stage directly downstream of the ALU control decoder.
- Accepts the 4-bit ALU control code and two operands over a valid/ready handshake, and returns result plus zero flag over a second valid/ready handshake.
- Logic ops and add/sub complete in 1 cycle. Shifts run iteratively, 1 bit per cycle, to keep area low.

Parameters:
- XLEN, 32, operand/result width in bits.
- SHAMT_W, 5, shift-amount width; must equal log2(XLEN).

Ports:
- clk, input, 1, single clock; all state changes on the rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- in_valid, input, 1, upstream holds a valid operation.
- in_ready, output, 1, unit can accept an operation.
- alu_ctrl, input, 4, operation code.
- op_a, input, XLEN, operand A.
- op_b, input, XLEN, operand B; bits [SHAMT_W-1:0] are the shift amount for shifts.
- out_valid, output, 1, result is valid.
- out_ready, input, 1, downstream accepts the result.
- result, output, XLEN, operation result.
- zero, output, 1, high when result is all zeros.
- illegal, output, 1, alu_ctrl was not a supported code.

Behaviour:
- Supported codes:
  - 0000 AND, 0001 OR, 0010 ADD, 0110 SUB: results modulo 2^XLEN, carries dropped.
  - 0111 SLT: signed A<B gives 1, else 0, zero-extended.
  - 0011 SLL, 0100 SRL, 0101 SRA.
  - Any other code is illegal: result=0, zero=1, illegal=1, latency 1.
- States:
  - IDLE: in_ready=1.
  - SHIFT: in_ready=0.
  - DONE: in_ready=0, out_valid=1.
- Accept: occurs at a rising edge where in_valid && in_ready. alu_ctrl, op_a and shamt are captured on that edge; later changes on the inputs are ignored.
- Non-shift op, or shift with shamt=0: result registered at the accept edge, go to DONE. out_valid is high the cycle after accept (latency 1).
- Shift with shamt=s>0:
  - Accept edge: load op_a into the working register, count=s, go to SHIFT.
  - Each SHIFT edge: shift 1 bit (SLL fills 0; SRL fills 0; SRA fills the bit at XLEN-1), decrement count.
  - The edge where count==1 moves to DONE.
  - out_valid rises s+1 cycles after accept. Worst case is XLEN cycles.
- DONE: result, zero and illegal are held stable while out_valid=1 && out_ready=0. The edge where out_ready=1 returns to IDLE, and out_valid drops the next cycle.
- No accept is possible in DONE or SHIFT, so back-to-back throughput is 2 cycles for 1-cycle ops.
- zero is computed from the final registered result, not the working value.
- out_ready asserted while out_valid=0 has no effect. in_valid low in IDLE means the unit stays IDLE.
- Reset (async, any state, including mid-shift):
  - state=IDLE, count=0.
  - result=0, zero=0, illegal=0, out_valid=0, in_ready=1 (once rst_n deasserts).
  - An in-flight operation is discarded.

Decomposition:
- Shared package alu_pkg holds:
  - ALU_AND/OR/ADD/SUB/SLT/SLL/SRL/SRA code constants, which the ALU control decoder also uses.
  - The state encoding IDLE/SHIFT/DONE.
  - XLEN default.
- One natural sub-module: alu_comb_core, combinational AND/OR/ADD/SUB/SLT plus illegal detect. The FSM, shift register and counter stay in alu_exec_unit.

Test Plan:
- Reset mid-shift: accept SLL with shamt=20, assert rst_n=0 after 5 cycles, release -> out_valid=0, result=0, in_ready=1; next ADD 3+4 -> result=7 one cycle after accept.
- ADD 0xFFFFFFFF+1 -> result=0, zero=1, latency 1. SUB 5-7 -> 0xFFFFFFFE, zero=0.
- SRA op_a=0x80000000 shamt=31 -> result=0xFFFFFFFF, out_valid exactly 32 cycles after accept. SRL same operands -> 0x00000001.
- Shift with shamt=0 (SLL 0x1234, op_b=0x20) -> result=0x1234 with latency 1 (op_b[4:0]=0).
- Backpressure: OR 0xF0|0x0F with out_ready held low 4 cycles -> result=0xFF stable, in_ready=0 throughout; accept completes on the first out_ready=1 edge; in_ready=1 the following cycle.
- Illegal code 1111 -> illegal=1, result=0, zero=1. SLT 0xFFFFFFFF vs 1 -> result=1.
